// File: rtl/ahb3lite_simple_master.sv
// ahb3lite_simple_master: single-outstanding AHB3-Lite master fed by a req/ack command port.
// Define AHB3LITE_MASTER_ALIGN_CHK_EN to reject misaligned or oversized commands locally.
module ahb3lite_simple_master #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,
    input  logic                  cmd_req,
    output logic                  cmd_ack,
    input  logic                  cmd_we,
    input  logic [HADDR_SIZE-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [HDATA_SIZE-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [HDATA_SIZE-1:0] rsp_rdata,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t                state;
    logic [HDATA_SIZE-1:0] wdata_q;
    logic                  local_err;

`ifdef AHB3LITE_MASTER_ALIGN_CHK_EN
    localparam logic [2:0] MAX_SIZE = (HDATA_SIZE == 64) ? 3'd3 : 3'd2;
    logic [2:0] low_mask;

    // Oversized commands are rejected before the mask matters, so three address bits suffice.
    always_comb begin
        case (cmd_size)
            3'd0:    low_mask = 3'b000;
            3'd1:    low_mask = 3'b001;
            3'd2:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
        local_err = (cmd_size > MAX_SIZE) || ((cmd_addr[2:0] & low_mask) != 3'b000);
    end
`else
    assign local_err = 1'b0;
`endif

    assign cmd_ack   = (state == IDLE);
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            HTRANS    <= TRANS_IDLE;
            HADDR     <= '0;
            HWDATA    <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'b000;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_req) begin
                        if (local_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state   <= ADDR;
                            HTRANS  <= TRANS_NONSEQ;
                            HADDR   <= cmd_addr;
                            HWRITE  <= cmd_we;
                            HSIZE   <= cmd_size;
                            wdata_q <= cmd_wdata;
                        end
                    end
                end
                ADDR: begin
                    if (HREADY) begin
                        state  <= DATA;
                        HTRANS <= TRANS_IDLE;
                        HWDATA <= wdata_q;
                    end
                end
                DATA: begin
                    // HWRITE still holds the command direction here, so it gates read capture.
                    if (HREADY) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= HRESP;
                        if (!HWRITE) begin
                            rsp_rdata <= HRDATA;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ahb3lite_simple_master.md
AHB3LITE_SIMPLE_MASTER -- requirements
Module: ahb3lite_simple_master

Interface
REQ-001 SHALL have parameter: HADDR_SIZE, 32, AHB address width.
REQ-002 SHALL have parameter: HDATA_SIZE, 32, AHB data width; only 32 and 64 are legal.
REQ-003 SHALL have port: HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: HCLK  input  1  clock; all logic is on its rising edge.
REQ-005 SHALL have port: cmd_req  input  1  command request.
REQ-006 SHALL have port: cmd_ack  output  1  command accepted when cmd_req and cmd_ack are both high.
REQ-007 SHALL have port: cmd_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: cmd_addr  input  HADDR_SIZE  byte address.
REQ-009 SHALL have port: cmd_size  input  3  HSIZE encoding.
REQ-010 SHALL have port: cmd_wdata  input  HDATA_SIZE  write data, already lane-aligned by the caller.
REQ-011 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: rsp_err  output  1  error flag, qualified by rsp_valid.
REQ-013 SHALL have port: rsp_rdata  output  HDATA_SIZE  read data, qualified by rsp_valid and not cmd_we.
REQ-014 SHALL have AHB3-Lite master ports HADDR, HWDATA (outputs); HRDATA (input); HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HTRANS[1:0], HMASTLOCK (outputs); HREADY, HRESP (inputs).

Function
REQ-015 SHALL implement an FSM with states IDLE, ADDR and DATA, and one outstanding transfer at a time.
REQ-016 SHALL drive cmd_ack high only in IDLE, combinationally from the state.
REQ-017 On accept, SHALL register cmd_addr, cmd_we, cmd_size and cmd_wdata, then move to ADDR on the next edge.
REQ-018 In ADDR, SHALL drive HTRANS=NONSEQ, HBURST=SINGLE, HPROT=4'b0011 and HMASTLOCK=0, with HADDR, HWRITE and HSIZE taken from the registered command.
REQ-019 SHALL hold ADDR and keep all address-phase signals stable while HREADY=0; when HREADY=1 it moves to DATA.
REQ-020 In DATA, SHALL drive HTRANS=IDLE and HWDATA=registered wdata, holding HWDATA stable until HREADY=1.
REQ-021 In DATA with HREADY=1, SHALL capture HRDATA into rsp_rdata and HRESP into rsp_err, pulse rsp_valid for exactly one cycle starting on the next edge, and return to IDLE.
REQ-022 In DATA with HRESP=ERROR and HREADY=0 (first error cycle), SHALL keep HTRANS=IDLE and wait; the error is reported on the HREADY=1 cycle.
REQ-023 Latency with a zero-wait slave: accept in cycle 0, address phase in cycle 1, data phase in cycle 2, rsp_valid in cycle 3; each slave wait state adds one cycle.
REQ-024 SHALL keep rsp_rdata at its last captured value on write completions.
REQ-025 SHALL keep HADDR, HWRITE and HSIZE at their last values while not in ADDR; only HTRANS indicates idle.
REQ-026 cmd_ack SHALL be high in the same cycle rsp_valid pulses, so back-to-back commands have a 3-cycle issue interval.

Reset
REQ-027 On HRESETn low, SHALL asynchronously set: state=IDLE; HTRANS=IDLE; HADDR=0; HWDATA=0; HWRITE=0; HSIZE=0; HBURST=0; HPROT=4'b0011; HMASTLOCK=0; rsp_valid=0; rsp_err=0; rsp_rdata=0.
REQ-028 cmd_ack SHALL be 1 during and directly after reset.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid pulse.

Configuration
REQ-030 Macro AHB3LITE_MASTER_ALIGN_CHK_EN SHALL control a local alignment check on accepted commands.
REQ-031 When the macro is defined, a command SHALL skip ADDR and DATA, produce no bus activity (HTRANS stays IDLE) and pulse rsp_valid=1 with rsp_err=1 on the edge after accept, if either:
- cmd_addr is not aligned to 2^cmd_size, or
- 2^cmd_size exceeds HDATA_SIZE/8.
REQ-032 When the macro is undefined, SHALL forward every command to the bus unchecked.

Verification
REQ-033 Zero-wait read: addr 0x10, size WORD, HRDATA=0xDEADBEEF -> HTRANS=NONSEQ in cycle 1; rsp_valid, rsp_err=0 and rsp_rdata=0xDEADBEEF in cycle 3.
REQ-034 Write with 2 wait states: addr 0x18, wdata 0x12345678, HREADY low for 2 data-phase cycles -> HWDATA stable for all 3 data cycles; rsp_valid in cycle 5.
REQ-035 Error response: HRESP=ERROR with HREADY 0 then 1 -> HTRANS=IDLE throughout; rsp_valid with rsp_err=1.
REQ-036 Address-phase stall: HREADY=0 for 3 cycles in ADDR -> HADDR, HTRANS and HSIZE unchanged; cmd_ack=0 throughout.
REQ-037 With AHB3LITE_MASTER_ALIGN_CHK_EN defined, addr 0x2 size WORD -> no NONSEQ issued; rsp_err=1 in cycle 1. With the macro undefined, the same command -> a bus transfer is issued.
REQ-038 HRESETn asserted in DATA -> all outputs take their reset values immediately; no rsp_valid pulse.
